// File: rtl/register_file_multi.sv
// ---------------------------------------------------------------------------
// register_file_multi
//   Parametrised CPU register file with NUM_REGS x DATA_W storage.
//   - NUM_READ combinational read ports with optional write->read bypass
//   - two write ports: A (ALU) and B (memory writeback); B wins on a tie
//   - per-register busy scoreboard (issue sets, write clears, issue wins)
//   - single T flag
//   - flattened registered snapshot for the VGA debug renderer
//   All state updates happen on the falling clock edge.
//
// Ports
//   clk           clock, state captured on negedge
//   rst           asynchronous reset, active low
//   readIndex     read port k index in [k*IDX_W +: IDX_W]
//   readResult    read port k data  in [k*DATA_W +: DATA_W]
//   readBusy      read port k: addressed register has a pending write
//   writeEnableA  active-low ALU write enable
//   writeIndexA   ALU write index
//   dataA         ALU write data
//   writeEnableB  active-low writeback enable
//   writeIndexB   writeback index
//   dataB         writeback data
//   issueEnable   active-low: mark issueIndex as pending
//   issueIndex    index to mark pending
//   tWriteEnable  active-low T flag load
//   tToWrite      new T flag value
//   tResult       T flag
//   busyMask      bit i set = register i pending
//   registersVGA  register 0 in the MS slice, register NUM_REGS-1 in the LS slice
// ---------------------------------------------------------------------------
module register_file_multi #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 11,
  parameter int IDX_W    = 4,
  parameter int NUM_READ = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_READ*IDX_W-1:0]    readIndex,
  output logic [NUM_READ*DATA_W-1:0]   readResult,
  output logic [NUM_READ-1:0]          readBusy,
  input  logic                         writeEnableA,
  input  logic [IDX_W-1:0]             writeIndexA,
  input  logic [DATA_W-1:0]            dataA,
  input  logic                         writeEnableB,
  input  logic [IDX_W-1:0]             writeIndexB,
  input  logic [DATA_W-1:0]            dataB,
  input  logic                         issueEnable,
  input  logic [IDX_W-1:0]             issueIndex,
  input  logic                         tWriteEnable,
  input  logic                         tToWrite,
  output logic                         tResult,
  output logic [NUM_REGS-1:0]          busyMask,
  output logic [NUM_REGS*DATA_W-1:0]   registersVGA
);

  localparam logic [IDX_W:0] NREG_W = (IDX_W+1)'(NUM_REGS);
  localparam logic           BYP_EN = (BYPASS != 0);
  localparam logic           ZR_EN  = (ZERO_REG != 0);

  // An index is live when it addresses a real register that is not the
  // hard-wired zero register.
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    idx_ok = ({1'b0, idx} < NREG_W) && !(ZR_EN && (idx == {IDX_W{1'b0}}));
  endfunction

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                t_q;
  logic                t_d;

  logic wr_a_s;
  logic wr_b_s;
  logic iss_s;

  assign wr_a_s = !writeEnableA && idx_ok(writeIndexA);
  assign wr_b_s = !writeEnableB && idx_ok(writeIndexB);
  assign iss_s  = !issueEnable  && idx_ok(issueIndex);

  // Next register/scoreboard state: B overrides A; an issue overrides the
  // clear from a write so the newer pending producer is tracked.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      logic hit_a;
      logic hit_b;
      logic hit_i;
      hit_a     = wr_a_s && (writeIndexA == IDX_W'(i));
      hit_b     = wr_b_s && (writeIndexB == IDX_W'(i));
      hit_i     = iss_s  && (issueIndex  == IDX_W'(i));
      regs_d[i] = hit_b ? dataB : (hit_a ? dataA : regs_q[i]);
      busy_d[i] = hit_i | (busy_q[i] & ~(hit_a | hit_b));
    end
  end

  // T flag next value.
  always_comb begin
    t_d = tWriteEnable ? t_q : tToWrite;
  end

  // State registers, falling-edge, async active-low clear.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      busy_q <= {NUM_REGS{1'b0}};
      t_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
      t_q    <= t_d;
    end
  end

  // Read ports: AND-OR mux over the registers, then optional bypass of
  // same-cycle writes. A bypassed register is reported not busy unless an
  // issue to it is also in flight this cycle.
  always_comb begin
    readResult = {(NUM_READ*DATA_W){1'b0}};
    readBusy   = {NUM_READ{1'b0}};
    for (int k = 0; k < NUM_READ; k++) begin
      logic [IDX_W-1:0]  rd_idx;
      logic [DATA_W-1:0] rd_data;
      logic              rd_busy;
      logic              rd_ok;
      logic              byp_a;
      logic              byp_b;
      logic              byp_i;
      rd_idx  = readIndex[k*IDX_W +: IDX_W];
      rd_ok   = idx_ok(rd_idx);
      rd_data = {DATA_W{1'b0}};
      rd_busy = 1'b0;
      for (int j = 0; j < NUM_REGS; j++) begin
        logic sel;
        sel     = rd_ok && (rd_idx == IDX_W'(j));
        rd_data = rd_data | (sel ? regs_q[j] : {DATA_W{1'b0}});
        rd_busy = rd_busy | (sel & busy_q[j]);
      end
      byp_a = BYP_EN && wr_a_s && (writeIndexA == rd_idx);
      byp_b = BYP_EN && wr_b_s && (writeIndexB == rd_idx);
      byp_i = iss_s && (issueIndex == rd_idx);
      readResult[k*DATA_W +: DATA_W] = byp_b ? dataB : (byp_a ? dataA : rd_data);
      readBusy[k] = ((byp_a | byp_b) && !byp_i) ? 1'b0 : rd_busy;
    end
  end

  // Registered snapshot, never bypassed.
  always_comb begin
    registersVGA = {(NUM_REGS*DATA_W){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      registersVGA[(NUM_REGS-1-i)*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign busyMask = busy_q;
  assign tResult  = t_q;

endmodule
